// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: sequences a W-bit add/sub through an external 4-bit adder,
// one slice per clock, least-significant slice first.
module adder_seq_ctrl #(
  parameter int NSLICE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [4*NSLICE-1:0]   op_a,
  input  logic [4*NSLICE-1:0]   op_b,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*NSLICE-1:0]   result,
  output logic                  cout,
  output logic                  ovf,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_sum,
  input  logic                  add_cout
);
  localparam int W  = 4 * NSLICE;
  localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [KW-1:0] r_k;
  logic [W-1:0] r_a, r_b, r_result;
  logic r_sub, r_carry, r_cout, r_ovf;
  logic w_accept, w_last, w_cmsb;
  assign w_accept = (r_state != RUN) && start;
  assign w_last   = r_k == KW'(NSLICE - 1);
  // The external adder hides its internal carries; recover the carry into bit 3.
  assign w_cmsb   = add_a[3] ^ add_b[3] ^ add_sum[3];
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = w_accept ? RUN :
             r_state == RUN  ? (w_last ? DONE : RUN) :
             r_state == DONE ? IDLE : r_state;
  end
  always_comb begin
    ready   = r_state != RUN;
    busy    = r_state == RUN;
    done    = r_state == DONE;
    add_a   = busy ? r_a[{r_k, 2'b00} +: 4] : 4'h0;
    add_b   = busy ? r_b[{r_k, 2'b00} +: 4] ^ {4{r_sub}} : 4'h0;
    add_cin = busy & r_carry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_k      <= '0;
      r_a      <= op_a;
      r_b      <= op_b;
      r_sub    <= sub;
      r_carry  <= sub;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == RUN) begin
      r_result[{r_k, 2'b00} +: 4] <= add_sum;
      r_carry <= add_cout;
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_cout <= add_cout;
        r_ovf  <= w_cmsb ^ add_cout;
      end
    end
  end
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed and random add/sub operations against an
// arithmetic reference model, with a behavioural 4-bit adder as the environment.
module tb_adder_seq_ctrl;
  localparam int NSLICE = 4;
  localparam int W = 4 * NSLICE;
  logic clk = 1'b0;
  logic rst, start, sub;
  logic [W-1:0] op_a, op_b, result;
  logic ready, busy, done, cout, ovf, add_cin, add_cout;
  logic [3:0] add_a, add_b, add_sum;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);
  adder_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .ready(ready), .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  // Carry into slice k: the carry out of the low 4k bits of a + bx + s.
  function automatic logic cin_ref(input logic [W-1:0] a, input logic [W-1:0] bx, input logic s, input int k);
    logic [W:0] mask, sum;
    mask = (W+1)'((64'd1 << (4 * k)) - 64'd1);
    sum  = ({1'b0, a} & mask) + ({1'b0, bx} & mask) + (W+1)'(s);
    return sum[4 * k];
  endfunction
  // mode 0: plain; 1: start pulse with new operands at slice 2; 2: reset at slice 2
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int mode);
    logic [W-1:0] bx;
    logic [W:0] sum;
    logic exp_ovf;
    bx = s ? ~b : b;
    sum = {1'b0, a} + {1'b0, bx} + (W+1)'(s);
    exp_ovf = (a[W-1] == bx[W-1]) && (sum[W-1] != a[W-1]);
    start = 1'b1; op_a = a; op_b = b; sub = s;
    @(negedge clk);
    start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
    chk("cleared_result", result, 0);
    for (int k = 0; k < NSLICE; k++) begin
      chk("busy", busy, 1);
      chk("ready_run", ready, 0);
      chk("done_run", done, 0);
      chk("add_a", add_a, a[4*k +: 4]);
      chk("add_b", add_b, bx[4*k +: 4]);
      chk("add_cin", add_cin, cin_ref(a, bx, s, k));
      if (k == 2 && mode == 1) start = 1'b1;
      if (k == 2 && mode == 2) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_add_a", add_a, 0);
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done", done, 1);
    chk("ready_done", ready, 1);
    chk("result", result, sum[W-1:0]);
    chk("cout", cout, sum[W]);
    chk("ovf", ovf, exp_ovf);
    chk("add_cin_idle", add_cin, 0);
  endtask
  task automatic idle_after(input logic [W-1:0] exp_res);
    @(negedge clk);
    chk("done_low", done, 0);
    chk("ready_idle", ready, 1);
    chk("held_result", result, exp_res);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_cout", cout, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 0); idle_after(16'h5555);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0); idle_after(16'h0000);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0); idle_after(16'h8000);
    run_op(16'h0005, 16'h0007, 1'b1, 0); idle_after(16'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b1, 0); idle_after(16'h7FFF);
    run_op(16'h1111, 16'h2222, 1'b0, 1);
    run_op(16'hABCD, 16'h1234, 1'b1, 0); idle_after(16'h9999);
    run_op(16'h0F0F, 16'h0101, 1'b0, 2);
    run_op(16'h0001, 16'h0001, 1'b0, 0); idle_after(16'h0002);
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      logic s;
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      if (i % 5 == 4) begin a[W-1] = 1'b1; b[W-1] = ~s; end
      run_op(a, b, s, 0);
      if ($urandom_range(0, 2) == 0) idle_after(s ? a - b : a + b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: NSLICE, 4, number of 4-bit slices per operation; operand width W = 4*NSLICE.
REQ-002 One clock, clk; reset is synchronous and active-high, rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request pulse; sampled only when ready=1.
REQ-006 sub  input  1  0 = A+B, 1 = A-B; latched with start.
REQ-007 op_a  input  W  operand A; latched with start.
REQ-008 op_b  input  W  operand B; latched with start.
REQ-009 ready  output  1  high when a start will be accepted.
REQ-010 busy  output  1  high while slices are being sequenced.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  W  registered sum/difference.
REQ-013 cout  output  1  final carry out; for sub, 1 = no borrow.
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 add_a  output  4  current A slice to the external 4-bit adder.
REQ-016 add_b  output  4  current B slice, already inverted when sub=1.
REQ-017 add_cin  output  1  carry into the current slice.
REQ-018 add_sum  input  4  combinational sum from the external adder, same cycle.
REQ-019 add_cout  input  1  combinational carry from the external adder, same cycle.

Function
REQ-020 FSM states: IDLE, RUN, DONE; slice index k is 0..NSLICE-1 and is valid in RUN.
REQ-021 ready=1 in IDLE and DONE, 0 in RUN; busy=1 only in RUN.
REQ-022 IDLE/DONE with start=1 at an edge: latch op_a, op_b and sub; set k=0 and carry=sub; go to RUN.
REQ-023 DONE with start=0: go to IDLE; done=1 only during DONE.
REQ-024 In RUN, slice k drives add_a=A[4k+3:4k], add_b=B[4k+3:4k] (XOR sub), and add_cin=carry register.
REQ-025 Each RUN edge: result[4k+3:4k] <= add_sum, carry <= add_cout, k <= k+1.
REQ-026 When k=NSLICE-1: also cout <= add_cout and ovf <= carry-into-MSB XOR add_cout; go to DONE.
REQ-027 Latency: start sampled at edge E0 -> RUN for NSLICE cycles -> done high for the cycle after edge E(NSLICE); default 4 slices = 4 busy cycles.
REQ-028 start while in RUN is ignored; latched operands are unaffected.
REQ-029 Input changes on op_a, op_b and sub during RUN have no effect.
REQ-030 result, cout and ovf are held from DONE until the next accepted start.
REQ-031 On an accepted start, result, cout and ovf are cleared to 0 on the same edge.
REQ-032 Arithmetic is modulo 2^W; the carry chain across slices is bit-exact with a W-bit ripple add.
REQ-033 Outside RUN, add_a, add_b and add_cin are driven to 0.

Reset
REQ-034 rst=1 at an edge forces IDLE, k=0, carry=0, result=0, cout=0, ovf=0 and done=0; ready=1, busy=0 on the following cycle.
REQ-035 rst has priority over start and over any RUN progress; reset mid-RUN aborts with no done pulse.

Verification
REQ-036 Add 0x1234+0x4321, sub=0 -> busy 4 cycles, done pulse, result=0x5555, cout=0, ovf=0.
REQ-037 Add 0xFFFF+0x0001 -> result=0x0000, cout=1, ovf=0; add_cin=1 on slices 1..3.
REQ-038 Add 0x7FFF+0x0001 -> result=0x8000, cout=0, ovf=1.
REQ-039 Sub 0x0005-0x0007 -> result=0xFFFE, cout=0; sub 0x8000-0x0001 -> result=0x7FFF, ovf=1.
REQ-040 Start pulsed during RUN slice 2 with different operands -> ignored; first result unchanged; back-to-back start in DONE accepted, with done low the next cycle.
REQ-041 rst asserted during RUN slice 2 -> no done; all outputs 0 next cycle; a subsequent 0x0001+0x0001 gives 0x0002.
